// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants and decoded-entry field layout shared by the decode queue
package decode_pkg;
  localparam logic [3:0] OP_POS    = 4'h0;
  localparam logic [3:0] OP_MEM    = 4'h1;
  localparam logic [3:0] OP_OFFSET = 4'h2;
  localparam logic [3:0] OP_FRAME  = 4'h3;
  localparam logic [3:0] OP_NOP    = 4'hF;
  localparam int OPC_LSB = 0;
  localparam int REG_LSB = 4;
  localparam int POS_REG_W = 5;
  localparam int MEM_REG_W = 14;
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_FRAME;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: first-word-fall-through FIFO with occupancy level output
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 50
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign valid = level != '0;
  // storage array needs no reset; validity comes from level
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap naturally at power-of-two depth; level tracks push/pop balance
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decodes sprite/frame instructions into a FWFT queue; DECODE_ERR_EN enables sticky error flags
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OPCODE_W = 4,
  parameter int REG_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [31:0]              dataA,
  input  logic [DATA_W-1:0]        dataB,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [OPCODE_W-1:0]      out_opcode,
  output logic [REG_W-1:0]         out_register,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_illegal,
  output logic                     err_overflow,
  input  logic                     err_clear
);
  localparam int EW = OPCODE_W + REG_W + DATA_W;
  localparam int LW = $clog2(DEPTH) + 1;
  logic [3:0] op;
  logic legal, push, pop, valid;
  logic [REG_W-1:0] reg_field;
  logic [EW-1:0] head;
  logic unused_ok;
  assign op = dataA[OPC_LSB +: 4];
  assign legal = is_legal(op);
  // register field selection; frame control carries no register
  always_comb
    reg_field = op == OP_MEM ? REG_W'(dataA[REG_LSB +: MEM_REG_W]) :
                op == OP_FRAME ? '0 : REG_W'(dataA[REG_LSB +: POS_REG_W]);
  assign pop = valid & out_ready;
  assign in_ready = level < LW'(DEPTH) || pop;
  assign push = clk_en & legal & in_ready;
  instr_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din({OPCODE_W'(op), reg_field, dataB}),
    .dout(head), .valid(valid), .level(level)
  );
  assign out_valid = valid;
  assign out_opcode = valid ? head[EW-1 -: OPCODE_W] : OPCODE_W'(OP_NOP);
  assign out_register = valid ? head[DATA_W +: REG_W] : '0;
  assign out_data = valid ? head[DATA_W-1:0] : '0;
  assign unused_ok = ^{dataA[31:18], err_clear};
`ifdef DECODE_ERR_EN
  // sticky flags: a same-cycle set wins over clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_illegal <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_illegal <= (clk_en & ~legal) | (err_illegal & ~err_clear);
      err_overflow <= (clk_en & legal & ~in_ready) | (err_overflow & ~err_clear);
    end
`else
  assign err_illegal = 1'b0;
  assign err_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: table-driven decode vectors plus directed FIFO/error/reset sequences
module tb_instr_decode_queue;
  localparam int DEPTH = 8;
`ifdef DECODE_ERR_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif
  logic clk = 0, reset = 1, clk_en = 0, out_ready = 0, err_clear = 0;
  logic [31:0] dataA = 0, dataB = 0;
  logic in_ready, out_valid, err_illegal, err_overflow;
  logic [3:0] out_opcode;
  logic [13:0] out_register;
  logic [31:0] out_data;
  logic [3:0] level;
  int tests = 0, fails = 0;

  instr_decode_queue dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .dataA(dataA), .dataB(dataB),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .out_opcode(out_opcode), .out_register(out_register), .out_data(out_data),
    .level(level), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [13:0] rg;
    logic [31:0] d;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  vec_t v [5];

  initial begin
    v[0] = '{32'h0000_0150, 32'h0064_00C8, 4'h0, 14'h0015, 32'h0064_00C8};
    v[1] = '{32'h0003_FFF1, 32'hDEAD_BEEF, 4'h1, 14'h3FFF, 32'hDEAD_BEEF};
    v[2] = '{32'h0003_FE52, 32'h0000_0042, 4'h2, 14'h0005, 32'h0000_0042};
    v[3] = '{32'hFFFF_FFF3, 32'h1234_5678, 4'h3, 14'h0000, 32'h1234_5678};
    v[4] = '{32'h0000_01F0, 32'h0000_0000, 4'h0, 14'h001F, 32'h0000_0000};
    cyc(); cyc();
    chk("rst_level", 64'(level), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_opcode", 64'(out_opcode), 64'hF);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_errs", 64'({err_illegal, err_overflow}), 0);
    reset = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      clk_en = 1; dataA = v[i].a; dataB = v[i].b;
      cyc();
      clk_en = 0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d_opcode", i), 64'(out_opcode), 64'(v[i].op));
      chk($sformatf("vec%0d_register", i), 64'(out_register), 64'(v[i].rg));
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(v[i].d));
      out_ready = 1;
      cyc();
      out_ready = 0;
      chk($sformatf("vec%0d_drained", i), 64'(level), 0);
      chk($sformatf("vec%0d_idle_reg", i), 64'(out_register), 0);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      clk_en = 1; dataA = 32'(i) << 4; dataB = 32'(i);
      if (i == DEPTH) begin
        #1;
        chk("full_in_ready", 64'(in_ready), 0);
        chk("full_level", 64'(level), DEPTH);
      end
      cyc();
    end
    clk_en = 0;
    chk("ovf_level", 64'(level), DEPTH);
    chk("ovf_flag", 64'(err_overflow), 64'(EN));
    err_clear = 1;
    cyc();
    err_clear = 0;
    chk("ovf_clear", 64'(err_overflow), 0);
    clk_en = 1; dataA = 32'h0000_00F0; dataB = 32'd100; out_ready = 1;
    #1;
    chk("full_pop_in_ready", 64'(in_ready), 1);
    cyc();
    clk_en = 0; out_ready = 0;
    chk("full_pop_level", 64'(level), DEPTH);
    chk("full_pop_no_ovf", 64'(err_overflow), 0);
    out_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_data", k), 64'(out_data), k < DEPTH - 1 ? 64'(k + 1) : 64'd100);
      cyc();
    end
    out_ready = 0;
    chk("drain_level", 64'(level), 0);
    chk("drain_valid", 64'(out_valid), 0);
    chk("drain_opcode", 64'(out_opcode), 64'hF);
    clk_en = 1; dataA = 32'h0000_0007;
    cyc();
    clk_en = 0;
    chk("ill_level", 64'(level), 0);
    chk("ill_flag", 64'(err_illegal), 64'(EN));
    clk_en = 1; err_clear = 1;
    cyc();
    clk_en = 0;
    chk("ill_set_beats_clear", 64'(err_illegal), 64'(EN));
    cyc();
    err_clear = 0;
    chk("ill_cleared", 64'(err_illegal), 0);
    for (int i = 1; i <= 3; i++) begin
      clk_en = 1; dataA = 32'(i) << 4; dataB = 32'(i * 7);
      cyc();
    end
    clk_en = 0;
    chk("mid_level", 64'(level), 3);
    #2;
    reset = 1;
    #1;
    chk("async_level", 64'(level), 0);
    chk("async_valid", 64'(out_valid), 0);
    chk("async_opcode", 64'(out_opcode), 64'hF);
    chk("async_data", 64'(out_data), 0);
    chk("async_in_ready", 64'(in_ready), 1);
    clk_en = 1; dataA = 32'h0000_0010;
    cyc(); cyc();
    clk_en = 0;
    reset = 0;
    chk("rst_discard_level", 64'(level), 0);
    cyc();
    chk("post_rst_level", 64'(level), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
